bcd_gated_counter: RTL and testbench

- Parametrised N-digit BCD event counter for the frequency-meter datapath, with a parallel binary counter.
- Counts Count_CP edges while En is high. On Store it latches the live count into stable output registers for the display and range logic.
- Successor to the fixed 4-digit counter. Adds a configurable digit count, selectable saturate/wrap overflow, sticky overflow flags, a latch-valid pulse and a leading-zero blank mask.

---
 rtl/bcd_gated_counter.sv | 133 +++++++++++++
 tb/tb_bcd_gated_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_gated_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_gated_counter                                             |
// | Purpose  : gated N-digit BCD + binary event counter with store latches,  |
// |            sticky overflow flags, leading-zero blank mask and Valid.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_gated_counter #(
  parameter int DIGITS   = 6,
  parameter int BIN_W    = 20,
  parameter int SATURATE = 1
) (
  input  logic                  Count_CP,
  input  logic                  RST,
  input  logic                  En,
  input  logic                  Clear,
  input  logic                  Store,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [BIN_W-1:0]      count,
  output logic                  BCD_Ovf,
  output logic                  Bin_Ovf,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Valid
);

  localparam logic              C_SAT       = (SATURATE != 0);
  localparam logic [DIGITS-1:0] C_BLANK_RST = ~((DIGITS)'(1));

  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_inc;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic                bcd_ovf_q, bcd_ovf_d, bin_ovf_q, bin_ovf_d;
  logic                bcd_wrap, bin_wrap, carry, zero_above;
  logic [DIGITS-1:0]   blank_w;

  logic [4*DIGITS-1:0] bcd_lat_q, bcd_lat_d;
  logic [BIN_W-1:0]    cnt_lat_q, cnt_lat_d;
  logic                bcd_ovf_lat_q, bcd_ovf_lat_d, bin_ovf_lat_q, bin_ovf_lat_d;
  logic [DIGITS-1:0]   blank_lat_q, blank_lat_d;
  logic                valid_q, valid_d;

  // Ripple the enable up through the digits; the carry out of the top
  // digit marks an all-nines increment, i.e. BCD overflow.
  always_comb begin
    bcd_inc = bcd_q;
    carry   = En;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (bcd_q[4*k +: 4] == 4'd9) bcd_inc[4*k +: 4] = 4'd0;
        else                         bcd_inc[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
      end
      carry = carry & (bcd_q[4*k +: 4] == 4'd9);
    end
    bcd_wrap = carry;
  end

  always_comb begin
    blank_w    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (bcd_q[4*k +: 4] == 4'd0);
      blank_w[k] = zero_above;
    end
    blank_w[0] = 1'b0;
  end

  always_comb begin
    bin_wrap = En & (&bin_q);
    if (Clear) begin
      bcd_d     = '0;
      bin_d     = '0;
      bcd_ovf_d = 1'b0;
      bin_ovf_d = 1'b0;
    end else begin
      bcd_d     = (bcd_wrap && C_SAT) ? bcd_q : bcd_inc;
      bin_d     = (bin_wrap && C_SAT) ? bin_q : bin_q + BIN_W'(En);
      bcd_ovf_d = bcd_ovf_q | bcd_wrap;
      bin_ovf_d = bin_ovf_q | bin_wrap;
    end
  end

  // Latches sample the pre-edge live state, so Store sees the value
  // from before any same-cycle increment or clear.
  always_comb begin
    bcd_lat_d     = bcd_lat_q;
    cnt_lat_d     = cnt_lat_q;
    bcd_ovf_lat_d = bcd_ovf_lat_q;
    bin_ovf_lat_d = bin_ovf_lat_q;
    blank_lat_d   = blank_lat_q;
    valid_d       = Store;
    if (Store) begin
      bcd_lat_d     = bcd_q;
      cnt_lat_d     = bin_q;
      bcd_ovf_lat_d = bcd_ovf_q;
      bin_ovf_lat_d = bin_ovf_q;
      blank_lat_d   = blank_w;
    end
  end

  always_ff @(posedge Count_CP or posedge RST) begin
    if (RST) begin
      bcd_q         <= '0;
      bin_q         <= '0;
      bcd_ovf_q     <= 1'b0;
      bin_ovf_q     <= 1'b0;
      bcd_lat_q     <= '0;
      cnt_lat_q     <= '0;
      bcd_ovf_lat_q <= 1'b0;
      bin_ovf_lat_q <= 1'b0;
      blank_lat_q   <= C_BLANK_RST;
      valid_q       <= 1'b0;
    end else begin
      bcd_q         <= bcd_d;
      bin_q         <= bin_d;
      bcd_ovf_q     <= bcd_ovf_d;
      bin_ovf_q     <= bin_ovf_d;
      bcd_lat_q     <= bcd_lat_d;
      cnt_lat_q     <= cnt_lat_d;
      bcd_ovf_lat_q <= bcd_ovf_lat_d;
      bin_ovf_lat_q <= bin_ovf_lat_d;
      blank_lat_q   <= blank_lat_d;
      valid_q       <= valid_d;
    end
  end

  assign BCD     = bcd_lat_q;
  assign count   = cnt_lat_q;
  assign BCD_Ovf = bcd_ovf_lat_q;
  assign Bin_Ovf = bin_ovf_lat_q;
  assign Blank   = blank_lat_q;
  assign Valid   = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_gated_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_gated_counter                                          |
// | Purpose  : scoreboard bench for four bcd_gated_counter configurations.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bcd_gated_counter;

  typedef struct packed {
    logic [31:0] bcd;
    logic [31:0] cnt;
    logic        bo;
    logic        bi;
    logic [7:0]  blank;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, clear, store;
  logic done = 1'b0;

  // d6: 6 digits/20b/sat, d4: 4 digits/20b/sat, d3s: 3 digits/10b/sat, d3w: 3 digits/10b/wrap
  logic [23:0] bcd6;  logic [19:0] cnt6; logic bo6, bi6, v6;  logic [5:0] bl6;
  logic [15:0] bcd4;  logic [19:0] cnt4; logic bo4, bi4, v4;  logic [3:0] bl4;
  logic [11:0] bcd3s; logic [9:0] cnt3s; logic bo3s, bi3s, v3s; logic [2:0] bl3s;
  logic [11:0] bcd3w; logic [9:0] cnt3w; logic bo3w, bi3w, v3w; logic [2:0] bl3w;

  always #5 clk = ~clk;

  bcd_gated_counter #(.DIGITS(6), .BIN_W(20), .SATURATE(1)) u_d6 (
    .Count_CP(clk), .RST(rst), .En(en), .Clear(clear), .Store(store),
    .BCD(bcd6), .count(cnt6), .BCD_Ovf(bo6), .Bin_Ovf(bi6), .Blank(bl6), .Valid(v6));
  bcd_gated_counter #(.DIGITS(4), .BIN_W(20), .SATURATE(1)) u_d4 (
    .Count_CP(clk), .RST(rst), .En(en), .Clear(clear), .Store(store),
    .BCD(bcd4), .count(cnt4), .BCD_Ovf(bo4), .Bin_Ovf(bi4), .Blank(bl4), .Valid(v4));
  bcd_gated_counter #(.DIGITS(3), .BIN_W(10), .SATURATE(1)) u_d3s (
    .Count_CP(clk), .RST(rst), .En(en), .Clear(clear), .Store(store),
    .BCD(bcd3s), .count(cnt3s), .BCD_Ovf(bo3s), .Bin_Ovf(bi3s), .Blank(bl3s), .Valid(v3s));
  bcd_gated_counter #(.DIGITS(3), .BIN_W(10), .SATURATE(0)) u_d3w (
    .Count_CP(clk), .RST(rst), .En(en), .Clear(clear), .Store(store),
    .BCD(bcd3w), .count(cnt3w), .BCD_Ovf(bo3w), .Bin_Ovf(bi3w), .Blank(bl3w), .Valid(v3w));

  exp_t  act [4];
  exp_t  rexp [4];
  exp_t  q [4][$];
  string nm [4] = '{"d6", "d4", "d3s", "d3w"};
  int    checks = 0;
  int    bad = 0;
  int    cycles = 0;

  always_comb begin
    act[0] = '{32'(bcd6),  32'(cnt6),  bo6,  bi6,  8'(bl6),  v6};
    act[1] = '{32'(bcd4),  32'(cnt4),  bo4,  bi4,  8'(bl4),  v4};
    act[2] = '{32'(bcd3s), 32'(cnt3s), bo3s, bi3s, 8'(bl3s), v3s};
    act[3] = '{32'(bcd3w), 32'(cnt3w), bo3w, bi3w, 8'(bl3w), v3w};
    rexp[0] = '{32'h0, 32'd0, 1'b0, 1'b0, 8'b111110, 1'b0};
    rexp[1] = '{32'h0, 32'd0, 1'b0, 1'b0, 8'b1110,   1'b0};
    rexp[2] = '{32'h0, 32'd0, 1'b0, 1'b0, 8'b110,    1'b0};
    rexp[3] = '{32'h0, 32'd0, 1'b0, 1'b0, 8'b110,    1'b0};
  end

  function automatic exp_t mk(logic [31:0] b, int c, logic bo, logic bi, logic [7:0] bl);
    return '{b, 32'(c), bo, bi, bl, 1'b1};
  endfunction

  task automatic push4(exp_t a, exp_t b, exp_t c, exp_t d);
    q[0].push_back(a);
    q[1].push_back(b);
    q[2].push_back(c);
    q[3].push_back(d);
  endtask

  task automatic step(input logic e, input logic c, input logic s, input int n);
    en = e; clear = c; store = s;
    repeat (n) @(posedge clk);
    #1;
    en = 1'b0; clear = 1'b0; store = 1'b0;
  endtask

  // Monitor: reset state while RST is high, otherwise pop one expectation per Valid.
  always @(negedge clk) begin
    exp_t e;
    cycles++;
    for (int i = 0; i < 4; i++) begin
      if (rst) e = rexp[i];
      else if (act[i].v && q[i].size() != 0) e = q[i].pop_front();
      else if (act[i].v) e = '0;
      else continue;
      checks++;
      if (act[i] !== e) begin
        bad++;
        $display("FAIL %s%s: got bcd=%h cnt=%0d ovf=%b/%b blank=%b valid=%b, want bcd=%h cnt=%0d ovf=%b/%b blank=%b valid=%b",
                 rst ? "reset_" : "latch_", nm[i], act[i].bcd, act[i].cnt, act[i].bo, act[i].bi,
                 act[i].blank, act[i].v, e.bcd, e.cnt, e.bo, e.bi, e.blank, e.v);
      end
    end
    if (done || cycles > 20000) begin
      if (!done) begin
        bad++;
        $display("FAIL timeout: got cycles=%0d, want done", cycles);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q[i].size() != 0) begin
          bad++;
          $display("FAIL pending_%s: got %0d unconsumed latches, want 0", nm[i], q[i].size());
        end
      end
      $display("test done: total=%0d bad=%0d", checks, bad);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; store = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Latch a small count, then hit RST asynchronously while counting.
    step(1, 0, 0, 7);
    push4(mk(32'h7, 7, 0, 0, 8'b111110), mk(32'h7, 7, 0, 0, 8'b1110),
          mk(32'h7, 7, 0, 0, 8'b110),    mk(32'h7, 7, 0, 0, 8'b110));
    step(0, 0, 1, 1);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // 1234 events: d3 variants overflow both BCD and 10-bit binary.
    step(0, 1, 0, 1);
    step(1, 0, 0, 1234);
    push4(mk(32'h001234, 1234, 0, 0, 8'b110000), mk(32'h1234, 1234, 0, 0, 8'b0000),
          mk(32'h999, 1023, 1, 1, 8'b000),       mk(32'h234, 210, 1, 1, 8'b000));
    step(0, 0, 1, 1);

    // Carry chain 999 -> 1000.
    step(0, 1, 0, 1);
    step(1, 0, 0, 999);
    push4(mk(32'h000999, 999, 0, 0, 8'b111000), mk(32'h0999, 999, 0, 0, 8'b1000),
          mk(32'h999, 999, 0, 0, 8'b000),        mk(32'h999, 999, 0, 0, 8'b000));
    step(0, 0, 1, 1);
    step(1, 0, 0, 1);
    push4(mk(32'h001000, 1000, 0, 0, 8'b110000), mk(32'h1000, 1000, 0, 0, 8'b0000),
          mk(32'h999, 1000, 1, 0, 8'b000),       mk(32'h000, 1000, 1, 0, 8'b110));
    step(0, 0, 1, 1);

    // 1005 events, then Clear and Store.
    step(0, 1, 0, 1);
    step(1, 0, 0, 1005);
    push4(mk(32'h001005, 1005, 0, 0, 8'b110000), mk(32'h1005, 1005, 0, 0, 8'b0000),
          mk(32'h999, 1005, 1, 0, 8'b000),       mk(32'h005, 1005, 1, 0, 8'b110));
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    push4(mk(32'h0, 0, 0, 0, 8'b111110), mk(32'h0, 0, 0, 0, 8'b1110),
          mk(32'h0, 0, 0, 0, 8'b110),    mk(32'h0, 0, 0, 0, 8'b110));
    step(0, 0, 1, 1);

    // Store + Clear + En on one edge, then Store again (two back-to-back Valids).
    step(0, 1, 0, 1);
    step(1, 0, 0, 50);
    push4(mk(32'h000050, 50, 0, 0, 8'b111100), mk(32'h0050, 50, 0, 0, 8'b1100),
          mk(32'h050, 50, 0, 0, 8'b100),       mk(32'h050, 50, 0, 0, 8'b100));
    step(1, 1, 1, 1);
    push4(mk(32'h0, 0, 0, 0, 8'b111110), mk(32'h0, 0, 0, 0, 8'b1110),
          mk(32'h0, 0, 0, 0, 8'b110),    mk(32'h0, 0, 0, 0, 8'b110));
    step(0, 0, 1, 1);

    step(0, 0, 0, 3);
    done = 1'b1;
  end

endmodule
`default_nettype wire
